// File: rtl/sipo_rx.sv
// sipo_rx: serial-in/parallel-out receiver.
// Reassembles WIDTH-bit words from a qualified serial stream (s_en marks the
// bits) and hands them to a consumer over a valid/ready interface. A word that
// completes while the previous one is still unconsumed is dropped and the
// sticky overrun flag is raised. clr flushes the partial word, the pending
// word and the overrun flag; p_out itself keeps its last value.
module sipo_rx #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_in,
   input  logic             s_en,
   input  logic             clr,
   output logic [WIDTH-1:0] p_out,
   output logic             p_valid,
   input  logic             p_ready,
   output logic             busy,
   output logic             overrun
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic {
      IDLE = 1'b0,
      RECV = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic [WIDTH-1:0] sh_shift;
   logic             word_done;

   // Shift register contents including the bit sampled on this edge.
   always_comb begin
      if (MSB_FIRST) begin
         sh_shift = {sh_q[WIDTH-2:0], s_in};
      end else begin
         sh_shift = {s_in, sh_q[WIDTH-1:1]};
      end
   end

   // Next-state logic: bit counting, word completion and flush.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sh_d      = sh_q;
      word_done = 1'b0;
      if (clr) begin
         // Flush wins over any bit arriving on the same edge.
         state_d = IDLE;
         cnt_d   = '0;
         sh_d    = '0;
      end else if (s_en) begin
         sh_d = sh_shift;
         unique case (state_q)
            IDLE: begin
               state_d = RECV;
               cnt_d   = CNT_ONE;
            end
            RECV: begin
               if (cnt_q == LAST_BIT) begin
                  // WIDTH-th bit: the word is complete on this edge.
                  state_d   = IDLE;
                  cnt_d     = '0;
                  word_done = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
      // s_en=0 leaves state, counter and shift register untouched.
   end

   // Receive-side state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sh_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sh_q    <= sh_d;
      end
   end

   // Output word, valid handshake and sticky overrun flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         p_out   <= '0;
         p_valid <= 1'b0;
         overrun <= 1'b0;
      end else if (clr) begin
         p_valid <= 1'b0;
         overrun <= 1'b0;
      end else if (word_done) begin
         if (!p_valid || p_ready) begin
            // Slot is free, or is being emptied on this very edge.
            p_out   <= sh_shift;
            p_valid <= 1'b1;
         end else begin
            // Consumer is stalled: drop the new word and remember it.
            overrun <= 1'b1;
         end
      end else if (p_valid && p_ready) begin
         p_valid <= 1'b0;
      end
   end

   assign busy = (state_q == RECV);

endmodule

// File: tb/tb_sipo_rx.sv
// tb_sipo_rx: self-checking bench for sipo_rx.
// Two instances (MSB-first and LSB-first) share all inputs. A hand-computed
// vector table, directed multi-cycle sequences and a randomized run are
// checked; the randomized run compares against a queue-based word model.
module tb_sipo_rx;

   localparam int W = 4;

   logic clk = 1'b0;
   logic rst, s_in, s_en, clr, p_ready;
   logic [W-1:0] pm, pl;
   logic vm, vl, bm, bl, om, ol;

   always #5 clk = ~clk;

   sipo_rx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
      .clk(clk), .rst(rst), .s_in(s_in), .s_en(s_en), .clr(clr),
      .p_out(pm), .p_valid(vm), .p_ready(p_ready), .busy(bm), .overrun(om)
   );

   sipo_rx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
      .clk(clk), .rst(rst), .s_in(s_in), .s_en(s_en), .clr(clr),
      .p_out(pl), .p_valid(vl), .p_ready(p_ready), .busy(bl), .overrun(ol)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: received bits of the current word, pending word, flags.
   bit           mq[$];
   logic         mv, movr;
   logic [W-1:0] mom, mol;

   typedef struct {
      bit         si, en, c, r;
      logic [3:0] em, el;
      bit         ev, eb, eo;
   } vec_t;

   vec_t tbl[14];

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      mv   = 1'b0;
      movr = 1'b0;
      mom  = '0;
      mol  = '0;
   endtask

   // One clock edge of the model using the inputs currently applied.
   task automatic model_step();
      bit           done;
      logic [W-1:0] wm, wl;
      done = 1'b0;
      wm   = '0;
      wl   = '0;
      if (clr) begin
         mq.delete();
         mv   = 1'b0;
         movr = 1'b0;
      end else begin
         if (s_en) begin
            mq.push_back(s_in);
            if (mq.size() == W) begin
               for (int i = 0; i < W; i++) begin
                  wm[W-1-i] = mq[i];
                  wl[i]     = mq[i];
               end
               mq.delete();
               done = 1'b1;
            end
         end
         if (done) begin
            if (!mv || p_ready) begin
               mom = wm;
               mol = wl;
               mv  = 1'b1;
            end else begin
               movr = 1'b1;
            end
         end else if (mv && p_ready) begin
            mv = 1'b0;
         end
      end
   endtask

   task automatic drive(bit si, bit en, bit c, bit r);
      s_in    = si;
      s_en    = en;
      clr     = c;
      p_ready = r;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      model_step();
   endtask

   task automatic cmp_model(string tag);
      chk({tag, ".pm"}, 32'(pm), 32'(mom));
      chk({tag, ".pl"}, 32'(pl), 32'(mol));
      chk({tag, ".vm"}, 32'(vm), 32'(mv));
      chk({tag, ".vl"}, 32'(vl), 32'(mv));
      chk({tag, ".bm"}, 32'(bm), 32'(mq.size() != 0));
      chk({tag, ".bl"}, 32'(bl), 32'(mq.size() != 0));
      chk({tag, ".om"}, 32'(om), 32'(movr));
      chk({tag, ".ol"}, 32'(ol), 32'(movr));
   endtask

   task automatic chk_zero(string tag);
      chk({tag, ".pm"}, 32'(pm), 32'd0);
      chk({tag, ".pl"}, 32'(pl), 32'd0);
      chk({tag, ".vm"}, 32'(vm), 32'd0);
      chk({tag, ".vl"}, 32'(vl), 32'd0);
      chk({tag, ".bm"}, 32'(bm), 32'd0);
      chk({tag, ".bl"}, 32'(bl), 32'd0);
      chk({tag, ".om"}, 32'(om), 32'd0);
      chk({tag, ".ol"}, 32'(ol), 32'd0);
   endtask

   initial begin
      bit       b4[8];
      bit       g_si[7];
      bit       g_en[7];
      bit       b6[4];
      bit [7:0] vobs;

      // si en clr rdy | p_out msb, p_out lsb | valid busy overrun
      tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0};
      tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0};
      tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0};
      tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'hA, 4'h5, 1'b1, 1'b0, 1'b0};
      tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'hA, 4'h5, 1'b1, 1'b1, 1'b0};
      tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'hA, 4'h5, 1'b1, 1'b1, 1'b0};
      tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'hA, 4'h5, 1'b1, 1'b1, 1'b0};
      tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'hA, 4'h5, 1'b1, 1'b0, 1'b1};
      tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'hA, 4'h5, 1'b0, 1'b0, 1'b1};
      tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'hA, 4'h5, 1'b0, 1'b0, 1'b0};
      tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'hA, 4'h5, 1'b0, 1'b0, 1'b0};
      tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'hA, 4'h5, 1'b0, 1'b0, 1'b0};
      tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'hA, 4'h5, 1'b0, 1'b1, 1'b0};
      tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'hA, 4'h5, 1'b0, 1'b0, 1'b0};

      b4   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      g_si = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      g_en = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      b6   = '{1'b0, 1'b0, 1'b1, 1'b1};

      // Reset state
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      #1 rst = 1'b0;
      @(posedge clk);
      #1;
      chk_zero("reset");
      model_reset();
      @(negedge clk);
      rst = 1'b1;

      // Table: single word, overrun, pop, clr, ignored ready, clr vs s_en
      for (int i = 0; i < 14; i++) begin
         drive(tbl[i].si, tbl[i].en, tbl[i].c, tbl[i].r);
         tick();
         chk($sformatf("tbl%0d.pm", i), 32'(pm), 32'(tbl[i].em));
         chk($sformatf("tbl%0d.pl", i), 32'(pl), 32'(tbl[i].el));
         chk($sformatf("tbl%0d.vm", i), 32'(vm), 32'(tbl[i].ev));
         chk($sformatf("tbl%0d.vl", i), 32'(vl), 32'(tbl[i].ev));
         chk($sformatf("tbl%0d.bm", i), 32'(bm), 32'(tbl[i].eb));
         chk($sformatf("tbl%0d.bl", i), 32'(bl), 32'(tbl[i].eb));
         chk($sformatf("tbl%0d.om", i), 32'(om), 32'(tbl[i].eo));
         chk($sformatf("tbl%0d.ol", i), 32'(ol), 32'(tbl[i].eo));
      end

      // Back-to-back words with s_en and p_ready held high
      vobs = '0;
      for (int i = 0; i < 8; i++) begin
         drive(b4[i], 1'b1, 1'b0, 1'b1);
         tick();
         cmp_model($sformatf("b2b%0d", i));
         vobs[i] = vm;
         if (i == 3) begin
            chk("b2b.word1m", 32'(pm), 32'hA);
            chk("b2b.word1l", 32'(pl), 32'h5);
         end
         if (i == 7) begin
            chk("b2b.word2m", 32'(pm), 32'h6);
            chk("b2b.word2l", 32'(pl), 32'h6);
         end
      end
      chk("b2b.pulses", 32'(vobs), 32'h88);
      chk("b2b.ovr", 32'(om), 32'd0);

      // Gaps between qualified bits
      for (int i = 0; i < 7; i++) begin
         drive(g_si[i], g_en[i], 1'b0, 1'b1);
         tick();
         cmp_model($sformatf("gap%0d", i));
         if (!g_en[i]) chk($sformatf("gap%0d.busy", i), 32'(bm), 32'd1);
      end
      chk("gap.pm", 32'(pm), 32'hA);
      chk("gap.pl", 32'(pl), 32'h5);
      chk("gap.v", 32'(vm), 32'd1);

      // Asynchronous reset in the middle of a word
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      tick();
      chk("abort.busy", 32'(bm), 32'd1);
      #2 rst = 1'b0;
      #1;
      chk_zero("async");
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(b6[i], 1'b1, 1'b0, 1'b0);
         tick();
         cmp_model($sformatf("fresh%0d", i));
      end
      chk("fresh.pm", 32'(pm), 32'h3);
      chk("fresh.pl", 32'(pl), 32'hC);
      chk("fresh.v", 32'(vm), 32'd1);
      chk("fresh.busy", 32'(bm), 32'd0);

      // Randomized stream against the model
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(0, 1)),
               ($urandom_range(0, 9) < 7),
               ($urandom_range(0, 39) == 0),
               1'($urandom_range(0, 1)));
         tick();
         cmp_model($sformatf("rnd%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sipo_rx.md
Name: sipo_rx

Overview:
- Serial-in/parallel-out receiver that sits directly downstream of the team's `piso` shifter.
- Consumes the qualified serial bit stream and reassembles WIDTH-bit words.
- Presents each word on a valid/ready parallel interface to the consumer.
- Flags overrun when a word completes before the consumer has taken the previous one.

Parameters:
- WIDTH, 4, word length in bits; legal range WIDTH >= 2.
- MSB_FIRST, 1, 1 = first received bit lands in p_out[WIDTH-1]; 0 = first received bit lands in p_out[0].

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- s_in  input  1  serial data bit.
- s_en  input  1  bit qualifier; s_in is sampled only on edges where s_en=1.
- clr  input  1  synchronous flush of partial word, output word and overrun flag.
- p_out  output  WIDTH  assembled parallel word.
- p_valid  output  1  p_out holds an unconsumed word.
- p_ready  input  1  consumer accepts p_out when p_valid & p_ready at a posedge.
- busy  output  1  partial word in progress (state RECV).
- overrun  output  1  sticky; a completed word was dropped.

Behaviour:
- Reset (rst=0, async): shift register=0, bit counter=0, state=IDLE, p_out=0, p_valid=0, busy=0, overrun=0. All outputs are held until rst returns to 1. A partial word is discarded.
- Priority at each posedge: clr > word completion/shift > consumer pop.
- FSM:
  - IDLE: counter=0. s_en=1 goes to RECV and takes counter to 1.
  - RECV: each s_en=1 increments the counter. On the WIDTH-th bit, return to IDLE with counter=0.
  - s_en=0 holds state, counter and shift register (gaps between bits are allowed).
  - busy = (state==RECV).
- Shift, MSB_FIRST=1: sh <= {sh[WIDTH-2:0], s_in}.
- Shift, MSB_FIRST=0: sh <= {s_in, sh[WIDTH-1:1]}.
- Completion word is the shift value including the bit sampled on that edge. It is not the stale register value.
- Completion edge, when !p_valid, or p_valid & p_ready on the same edge:
  - p_out <= completion word; p_valid <= 1.
  - Latency: p_valid is high in the cycle after the edge sampling the WIDTH-th bit.
- Completion edge, when p_valid & !p_ready:
  - Word is dropped; p_out and p_valid are unchanged.
  - overrun <= 1, sticky until clr or reset.
- Pop: p_valid & p_ready with no completion on that edge gives p_valid <= 0. p_out keeps its last value.
- p_ready while p_valid=0 is ignored.
- clr=1: counter=0, state=IDLE, sh=0, p_valid=0, overrun=0. p_out is unchanged. s_en on the same edge is ignored.
- Counter width is $clog2(WIDTH). It wraps to 0 only via completion, never by overflow.
- Back-to-back words with s_en held high and p_ready held high produce one p_valid pulse every WIDTH cycles, with no lost bits.

Test Plan:
1. Reset, then s_en=1 for 4 cycles with s_in=1,0,1,0 (WIDTH=4, MSB_FIRST=1), p_ready=0 -> p_out=4'b1010, p_valid=1 the cycle after the 4th bit, busy=1 during bits 1-3 and 0 after, overrun=0.
2. Same stream with MSB_FIRST=0 -> p_out=4'b0101.
3. Word 1010 pending with p_ready=0, then second word 1100 streamed -> overrun=1, p_out stays 1010. Then p_ready=1 for one cycle -> p_valid=0, overrun stays 1. clr=1 -> overrun=0.
4. p_ready held 1, s_en held 1, bits 1,0,1,0,0,1,1,0 -> two p_valid pulses four cycles apart, p_out=1010 then 0110, overrun=0. The second completion coincides with neither a stall nor a loss.
5. s_en gaps (s_in=1,_,0,_,_,1,0 with s_en low on the gaps) -> p_out=1010. Counter and shift register hold during gaps.
6. Two bits received (busy=1), then rst=0 mid-cycle -> all outputs 0 immediately without waiting for clk. After release, a fresh 4-bit 0011 gives p_out=0011 with no residue from the aborted word.
